// File: rtl/mem_stage.sv
// Data-memory pipeline stage: captures an EX result, performs a word load/store
// with a programmable latency, and presents a registered writeback bundle.
module mem_stage #(
  parameter int DEPTH       = 64,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_flag_mem_in,
  input  logic        valid_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic        mem_to_reg,
  input  logic [4:0]  write_reg,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        stall_flag_mem_out,
  output logic        mem_busy,
  output logic        valid_out,
  output logic [31:0] read_data,
  output logic [31:0] alu_result_out,
  output logic [4:0]  write_reg_out,
  output logic        reg_write_out,
  output logic        mem_to_reg_out,
  output logic        misaligned
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT     = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 2);

  logic [0:0]    state;
  logic [3:0]    cnt;
  logic          pend;
  logic          p_rd, p_wr, p_rw, p_m2r;
  logic [4:0]    p_wreg;
  logic [31:0]   p_addr, p_sdata;
  logic [31:0]   mem [0:DEPTH-1] = '{default: '0};

  logic          cap, fire, p_mem, bad;
  logic [AW-1:0] idx;

  // The captured op is held in pend until the FSM is back in IDLE; the access
  // and the output pulse happen together on that edge.
  assign cap      = (state == IDLE) && valid_in && !stall_flag_mem_in;
  assign fire     = pend && (state == IDLE);
  assign p_mem    = p_rd || p_wr;
  assign bad      = p_mem && ((p_addr[1:0] != 2'b00) ||
                              ({2'b00, p_addr[31:2]} >= 32'(DEPTH)));
  assign idx      = p_addr[AW+1:2];
  assign mem_busy = (state == WAIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= 1'b0;
      p_rd    <= 1'b0;
      p_wr    <= 1'b0;
      p_rw    <= 1'b0;
      p_m2r   <= 1'b0;
      p_wreg  <= '0;
      p_addr  <= '0;
      p_sdata <= '0;
    end else begin
      if (cap) begin
        pend    <= 1'b1;
        p_rd    <= mem_read;
        p_wr    <= mem_write;
        p_rw    <= reg_write;
        p_m2r   <= mem_to_reg;
        p_wreg  <= write_reg;
        p_addr  <= alu_result;
        p_sdata <= store_data;
      end else if (fire) begin
        pend <= 1'b0;
      end
      if (state == IDLE) begin
        if (cap && (mem_read || mem_write) && (MEM_LATENCY > 1)) begin
          state <= WAIT;
          cnt   <= CNT_INIT;
        end
      end else if (cnt == 4'd0) begin
        state <= IDLE;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_flag_mem_out <= 1'b0;
      valid_out          <= 1'b0;
      misaligned         <= 1'b0;
      read_data          <= '0;
      alu_result_out     <= '0;
      write_reg_out      <= '0;
      reg_write_out      <= 1'b0;
      mem_to_reg_out     <= 1'b0;
    end else begin
      stall_flag_mem_out <= stall_flag_mem_in;
      valid_out          <= fire;
      misaligned         <= fire && bad;
      if (fire) begin
        // Read-before-write: a combined load/store returns the old word.
        read_data      <= (p_rd && !bad) ? mem[idx] : '0;
        alu_result_out <= p_addr;
        write_reg_out  <= p_wreg;
        reg_write_out  <= p_rw && !bad && !(p_wr && !p_rd);
        mem_to_reg_out <= p_m2r;
      end
    end
  end

  // Memory is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (fire && p_wr && !bad) mem[idx] <= p_sdata;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: latency-2 instance for the main traffic and a
// latency-4 instance for the long-access case.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_in = 1'b0, valid_in = 1'b0, valid4 = 1'b0;
  logic        rd = 1'b0, wr = 1'b0, rw = 1'b0, m2r = 1'b0;
  logic [4:0]  wreg = '0;
  logic [31:0] addr = '0, sdata = '0;

  logic        stall_out, busy, vout, rw_out, m2r_out, mis;
  logic [31:0] rdata, aout;
  logic [4:0]  wout;
  logic        stall_out4, busy4, vout4, rw_out4, m2r_out4, mis4;
  logic [31:0] rdata4, aout4;
  logic [4:0]  wout4;

  int cyc = 0;
  int checks = 0;
  int errs = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [4:0]  wreg;
    logic        rw;
    logic        m2r;
    logic        mis;
    int          cyc;
  } exp_t;
  exp_t q[$];
  exp_t q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_stage #(.DEPTH(64), .MEM_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .stall_flag_mem_in(stall_in), .valid_in(valid_in),
    .mem_read(rd), .mem_write(wr), .reg_write(rw), .mem_to_reg(m2r),
    .write_reg(wreg), .alu_result(addr), .store_data(sdata),
    .stall_flag_mem_out(stall_out), .mem_busy(busy), .valid_out(vout),
    .read_data(rdata), .alu_result_out(aout), .write_reg_out(wout),
    .reg_write_out(rw_out), .mem_to_reg_out(m2r_out), .misaligned(mis)
  );

  mem_stage #(.DEPTH(64), .MEM_LATENCY(4)) dut4 (
    .clk(clk), .reset(reset), .stall_flag_mem_in(stall_in), .valid_in(valid4),
    .mem_read(rd), .mem_write(wr), .reg_write(rw), .mem_to_reg(m2r),
    .write_reg(wreg), .alu_result(addr), .store_data(sdata),
    .stall_flag_mem_out(stall_out4), .mem_busy(busy4), .valid_out(vout4),
    .read_data(rdata4), .alu_result_out(aout4), .write_reg_out(wout4),
    .reg_write_out(rw_out4), .mem_to_reg_out(m2r_out4), .misaligned(mis4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic [31:0] last_a = '0, last_d = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        last_a = '0;
        last_d = '0;
      end else begin
        if (vout) begin
          if (q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
          else begin
            e = q.pop_front();
            chk("valid_cycle", cyc, e.cyc);
            chk("read_data", rdata, e.rdata);
            chk("alu_result_out", aout, e.addr);
            chk("write_reg_out", {27'd0, wout}, {27'd0, e.wreg});
            chk("reg_write_out", {31'd0, rw_out}, {31'd0, e.rw});
            chk("mem_to_reg_out", {31'd0, m2r_out}, {31'd0, e.m2r});
            chk("misaligned", {31'd0, mis}, {31'd0, e.mis});
          end
          last_a = aout;
          last_d = rdata;
        end else begin
          chk("hold_alu_result_out", aout, last_a);
          chk("hold_read_data", rdata, last_d);
          chk("misaligned_idle", {31'd0, mis}, 32'd0);
        end
        if (vout4) begin
          if (q4.size() == 0) chk("unexpected_valid4", 32'd1, 32'd0);
          else begin
            e = q4.pop_front();
            chk("valid_cycle4", cyc, e.cyc);
            chk("read_data4", rdata4, e.rdata);
            chk("reg_write_out4", {31'd0, rw_out4}, {31'd0, e.rw});
            chk("misaligned4", {31'd0, mis4}, {31'd0, e.mis});
          end
        end
      end
    end
  endtask

  // Called just after a posedge; returns just after the capture edge.
  task automatic send(input bit d4, input logic i_rd, i_wr, i_rw, i_m2r,
                      input logic [4:0] i_wreg, input logic [31:0] i_addr, i_sd,
                      input logic [31:0] e_rd, input logic e_rw, e_mis);
    int n = 0;
    exp_t e;
    while ((d4 ? busy4 : busy) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("busy_timeout", 32'd1, 32'd0);
    rd = i_rd; wr = i_wr; rw = i_rw; m2r = i_m2r;
    wreg = i_wreg; addr = i_addr; sdata = i_sd;
    if (d4) valid4 = 1'b1; else valid_in = 1'b1;
    e = '{e_rd, i_addr, i_wreg, e_rw, i_m2r, e_mis,
          cyc + 1 + ((i_rd || i_wr) ? (d4 ? 4 : 2) : 1)};
    if (d4) q4.push_back(e); else q.push_back(e);
    @(posedge clk); #1;
    valid_in = 1'b0; valid4 = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || q4.size() != 0) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("queue_drained", q.size() + q4.size(), 32'd0);
  endtask

  initial begin
    int nb;
    fork monitor(); join_none

    // Reset state, with stall high to show it is forced low.
    stall_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", {31'd0, vout}, 32'd0);
    chk("rst_mem_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall_out", {31'd0, stall_out}, 32'd0);
    chk("rst_read_data", rdata, 32'd0);
    chk("rst_alu_result_out", aout, 32'd0);
    chk("rst_reg_write_out", {31'd0, rw_out}, 32'd0);
    chk("rst_misaligned", {31'd0, mis}, 32'd0);
    stall_in = 1'b0;
    reset = 1'b1;

    // Store then load.
    send(0, 0, 1, 0, 0, 5'd0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    send(0, 1, 0, 1, 1, 5'd3, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);

    // R-type: single-cycle, never busy.
    send(0, 0, 0, 1, 0, 5'd5, 32'd7, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("rtype_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("rtype_busy_next", {31'd0, busy}, 32'd0);

    // Bad addresses, then confirm memory untouched.
    send(0, 1, 0, 1, 1, 5'd4, 32'h13, 32'h0, 32'h0, 1'b0, 1'b1);
    send(0, 1, 0, 1, 1, 5'd4, 32'h100, 32'h0, 32'h0, 1'b0, 1'b1);
    send(0, 0, 1, 0, 0, 5'd0, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1);
    send(0, 1, 0, 1, 1, 5'd6, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    send(0, 1, 0, 1, 1, 5'd6, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);

    // Combined load/store returns the old word.
    send(0, 1, 1, 1, 1, 5'd7, 32'h10, 32'hCAFEF00D, 32'hDEADBEEF, 1'b1, 1'b0);
    send(0, 1, 0, 1, 1, 5'd8, 32'h10, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0);
    drain();

    // Stall blocks capture; stall is echoed one cycle later.
    stall_in = 1'b1; valid_in = 1'b1; rd = 1'b1; addr = 32'h10;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_out_high", {31'd0, stall_out}, 32'd1);
      chk("stall_no_busy", {31'd0, busy}, 32'd0);
    end
    stall_in = 1'b0; valid_in = 1'b0; rd = 1'b0;
    @(posedge clk); #1;
    chk("stall_out_low", {31'd0, stall_out}, 32'd0);
    chk("stall_no_valid", {31'd0, vout}, 32'd0);

    // Reset during WAIT aborts the store.
    wr = 1'b1; rw = 1'b0; addr = 32'h20; sdata = 32'h1234; wreg = 5'd2; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0; wr = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_busy_low", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, vout}, 32'd0);
    chk("abort_alu_result_out", aout, 32'd0);
    chk("abort_read_data", rdata, 32'd0);
    chk("abort_write_reg_out", {27'd0, wout}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    send(0, 1, 0, 1, 1, 5'd9, 32'h20, 32'h0, 32'h0, 1'b1, 1'b0);
    drain();

    // Latency 4: store, then load with a busy-cycle count.
    send(1, 0, 1, 0, 0, 5'd0, 32'h8, 32'h55AA, 32'h0, 1'b0, 1'b0);
    send(1, 1, 0, 1, 1, 5'd10, 32'h8, 32'h0, 32'h55AA, 1'b1, 1'b0);
    nb = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy4) nb++;
    end
    chk("lat4_busy_cycles", nb, 32'd3);
    @(posedge clk); #1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
